flag_unit: RTL

//  Producer end of the NZCV condition-flag interface. Computes N/Z/C/V from ALU operands and

---
 rtl/flag_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/flag_unit.sv
// NZCV flag producer: computes condition flags from ALU operands, holds the architectural
// flag register and a one-deep shadow copy for exception save/restore.
module flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Valid,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             FlagLoad,
  input  logic [3:0]       FlagsIn,
  input  logic             FlagSave,
  input  logic             FlagRestore,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext,
  output logic [3:0]       ShadowFlags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             is_sub;
  logic             is_logic;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  logic             upd;

  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [3:0]       shadow_q;
  logic [3:0]       shadow_d;

  assign is_sub   = (ALUControl == 2'b01);
  assign is_logic = ALUControl[1];

  // SUB is A + ~B + 1, so C=1 means no borrow
  assign bx  = is_sub ? ~SrcB : SrcB;
  assign sum = {1'b0, SrcA} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    result = sum[WIDTH-1:0];
    case (ALUControl)
      2'b10:   result = SrcA & SrcB;
      2'b11:   result = SrcA | SrcB;
      default: result = sum[WIDTH-1:0];
    endcase
  end

  assign alu_n = result[MSB];
  assign alu_z = (result == '0);
  assign alu_c = is_logic ? 1'b0 : sum[WIDTH];
  assign alu_v = is_logic ? 1'b0
               : ((SrcA[MSB] == bx[MSB]) & (result[MSB] != SrcA[MSB]));

  assign upd = En & Valid & CondEx;

  // Priority: reset > restore > load > ALU update; the unselected pair holds
  always_comb begin
    flags_d = flags_q;
    if (reset) begin
      flags_d = 4'b0000;
    end else if (En && FlagRestore) begin
      flags_d = shadow_q;
    end else if (En && FlagLoad) begin
      flags_d = FlagsIn;
    end else if (upd) begin
      if (FlagW[1]) begin
        flags_d[3] = alu_n;
        flags_d[2] = alu_z;
      end
      if (FlagW[0]) begin
        flags_d[1] = alu_c;
        flags_d[0] = alu_v;
      end
    end
  end

  // Save samples the pre-edge flags, so save+restore in one cycle swaps
  always_comb begin
    shadow_d = shadow_q;
    if (reset) begin
      shadow_d = 4'b0000;
    end else if (En && FlagSave) begin
      shadow_d = flags_q;
    end
  end

  always_ff @(posedge clk) begin
    flags_q  <= flags_d;
    shadow_q <= shadow_d;
  end

  assign Flags       = flags_q;
  assign FlagsNext   = flags_d;
  assign ShadowFlags = shadow_q;

endmodule
